burst_transceiver_seq: RTL

// - Parametrised sequencer for the pulse-propagation meter radio front end; successor to the single-shot TX/RX top-level control.
// - Fully synchronous to i_Clk. Provides a DAC bring-up handshake and antenna/amplifier switching with guard times.
// - Two modes:
//   - Initiator: bursts of up to MAX_BURST pulses, each with a response timeout.
//   - Transponder: replies to received pulses after a fixed delay.
// - Sits between the STM32 trigger, the RF switches, the external SPI DAC master and the TDC START/STOP pins.

---
 rtl/burst_transceiver_seq.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/burst_transceiver_seq.sv
// Burst TX/RX sequencer: DAC bring-up, guarded antenna switching, initiator/transponder modes.
// Define BTS_STATS_EN to add saturating answered/timeout pulse counters.
module burst_transceiver_seq #(
  parameter int PULSE_CYCLES   = 4,
  parameter int GUARD_CYCLES   = 8,
  parameter int REPLY_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int MAX_BURST      = 8,
  localparam int BW = $clog2(MAX_BURST + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_L,
  input  logic          i_Mode,
  input  logic          i_Trigger,
  input  logic [BW-1:0] i_BurstLen,
  input  logic          i_ReceivedData,
  input  logic          i_DacReady,
  output logic          o_DacStart,
  output logic          o_Busy,
  output logic          o_DataIn,
  output logic          o_Start,
  output logic          o_Stop,
  output logic          o_AntennaTx,
  output logic          o_AntennaRx,
  output logic          o_EnAmp,
  output logic          o_EnRxPower,
  output logic          o_EnLna,
  output logic          o_Done,
  output logic          o_Timeout
`ifdef BTS_STATS_EN
  ,
  output logic [15:0]   o_OkCount,
  output logic [15:0]   o_ToCount
`endif
);

  localparam int M1 = (PULSE_CYCLES > GUARD_CYCLES) ? PULSE_CYCLES : GUARD_CYCLES;
  localparam int M2 = (REPLY_CYCLES > M1) ? REPLY_CYCLES : M1;
  localparam int MAXC = (TIMEOUT_CYCLES > M2) ? TIMEOUT_CYCLES : M2;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] PULSE_END = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_END = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] REPLY_END = CW'(REPLY_CYCLES - 1);
  localparam logic [CW-1:0] TMO_END   = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_DAC, S_IDLE, S_TXG, S_TXP,
    S_RXG, S_RXW, S_RXL, S_RPW
  } state_t;

  state_t r_State, w_Next;
  logic [CW-1:0] r_Cnt;
  logic [BW-1:0] r_Left;
  logic r_Init, r_RxSeen;
  logic [1:0] r_TrigSync, r_RxSync;
  logic r_TrigD, r_RxD;
  logic w_TrigRise, w_RxRise, w_RxFall;
  logic w_Timed, w_PulseEnd;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_TrigSync <= '0;
      r_RxSync   <= '0;
      r_TrigD    <= 1'b0;
      r_RxD      <= 1'b0;
    end else begin
      r_TrigSync <= {r_TrigSync[0], i_Trigger};
      r_RxSync   <= {r_RxSync[0], i_ReceivedData};
      r_TrigD    <= r_TrigSync[1];
      r_RxD      <= r_RxSync[1];
    end
  end

  assign w_TrigRise = r_TrigSync[1] & ~r_TrigD;
  assign w_RxRise   = r_RxSync[1] & ~r_RxD;
  assign w_RxFall   = ~r_RxSync[1] & r_RxD;
  assign w_PulseEnd = (r_State == S_TXP) && (r_Cnt == PULSE_END);

  always_comb begin
    w_Next    = r_State;
    o_Done    = 1'b0;
    o_Timeout = 1'b0;
    unique case (r_State)
      S_DAC:  if (i_DacReady) w_Next = S_IDLE;
      S_IDLE: begin
        if (!i_Mode) w_Next = S_RXG;
        else if (w_TrigRise) w_Next = S_TXG;
      end
      S_TXG:  if (r_Cnt == GUARD_END) w_Next = S_TXP;
      S_TXP: begin
        if (r_Cnt == PULSE_END) begin
          w_Next = S_RXG;
          o_Done = ~r_Init;
        end
      end
      S_RXG: begin
        if (r_Cnt == GUARD_END) w_Next = r_Init ? S_RXW : S_RXL;
      end
      S_RXW: begin
        // an echo edge beats a simultaneous timeout
        o_Timeout = ~w_RxRise & (r_Cnt == TMO_END);
        if (w_RxRise || o_Timeout) begin
          if (r_Left != '0) begin
            w_Next = S_TXG;
          end else begin
            w_Next = S_IDLE;
            o_Done = 1'b1;
          end
        end
      end
      S_RXL: begin
        if (i_Mode) w_Next = S_IDLE;
        else if (r_RxSeen && w_RxFall) w_Next = S_RPW;
      end
      S_RPW:  if (r_Cnt == REPLY_END) w_Next = S_TXG;
      default: w_Next = S_DAC;
    endcase
  end

  assign w_Timed = (r_State == S_TXG) || (r_State == S_TXP) ||
                   (r_State == S_RXG) || (r_State == S_RXW) ||
                   (r_State == S_RPW);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_State  <= S_DAC;
      r_Cnt    <= '0;
      r_Left   <= '0;
      r_Init   <= 1'b0;
      r_RxSeen <= 1'b0;
    end else begin
      r_State <= w_Next;
      if (w_Next != r_State) r_Cnt <= '0;
      else if (w_Timed) r_Cnt <= r_Cnt + CW'(1);
      if (w_Next != r_State) r_RxSeen <= 1'b0;
      else if (r_State == S_RXL && w_RxRise) r_RxSeen <= 1'b1;
      if (r_State == S_IDLE) r_Init <= i_Mode;
      if (r_State == S_IDLE && i_Mode && w_TrigRise)
        r_Left <= (i_BurstLen == '0) ? BW'(1) : i_BurstLen;
      else if (w_PulseEnd && r_Init && r_Left != '0)
        r_Left <= r_Left - BW'(1);
    end
  end

  assign o_DacStart  = (r_State == S_DAC);
  assign o_Busy      = (r_State != S_DAC) && (r_State != S_IDLE);
  assign o_AntennaTx = (r_State == S_TXG) || (r_State == S_TXP);
  assign o_EnAmp     = o_AntennaTx;
  assign o_AntennaRx = (r_State == S_RXG) || (r_State == S_RXW) ||
                       (r_State == S_RXL) || (r_State == S_RPW);
  assign o_EnRxPower = o_AntennaRx;
  assign o_EnLna     = o_AntennaRx;
  assign o_DataIn    = (r_State != S_TXP);
  assign o_Start     = (r_State == S_TXP) && r_Init;
  assign o_Stop      = i_ReceivedData && (r_State == S_RXW);

`ifdef BTS_STATS_EN
  logic [15:0] r_OkCount, r_ToCount;
  logic w_Answer;

  assign w_Answer = (r_State == S_RXW) && w_RxRise;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_OkCount <= '0;
      r_ToCount <= '0;
    end else begin
      if (w_Answer && r_OkCount != 16'hFFFF)
        r_OkCount <= r_OkCount + 16'd1;
      if (o_Timeout && r_ToCount != 16'hFFFF)
        r_ToCount <= r_ToCount + 16'd1;
    end
  end

  assign o_OkCount = r_OkCount;
  assign o_ToCount = r_ToCount;
`endif

endmodule
